// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Two-input datapath multiplexer: y = sel ? d1 : d0.
module mem_port_arbiter_mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-ported memory between the fetch port and
// the load/store port; one access in flight, fixed read latency MEM_LAT.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MEM_LAT + 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT out of range 1..15");
        end
    endgenerate

    state_t        state;
    logic          owner_q;
    logic          last_gnt;
    logic [CW-1:0] cnt;
    logic [31:0]   cnt_w;
    logic          owner_sel;
    logic          issue;

    // Under contention the port that did not win last time gets the access.
    always_comb begin
        owner_sel = REQ_IF;
        if (if_req && dm_req) begin
            owner_sel = ~last_gnt;
        end else if (dm_req) begin
            owner_sel = REQ_DM;
        end
    end

    assign issue     = (state == IDLE) && (if_req || dm_req);
    assign if_gnt    = issue && (owner_sel == REQ_IF);
    assign dm_gnt    = issue && (owner_sel == REQ_DM);
    assign mem_en    = issue;
    assign mem_we    = issue && (owner_sel == REQ_DM) && dm_we;
    assign mem_wdata = (issue && (owner_sel == REQ_DM)) ? dm_wdata : '0;
    assign rdata     = mem_rdata;
    assign cnt_w     = {{(32-CW){1'b0}}, cnt};

    mem_port_arbiter_mux2 #(
        .WIDTH (AW)
    ) u_addr_mux (
        .sel (owner_sel),
        .d0  (if_addr),
        .d1  (dm_addr),
        .y   (mem_addr)
    );

    // rvalid is registered, so it is raised on the edge entering the cnt == 1 cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner_q   <= REQ_IF;
            last_gnt  <= REQ_IF;
            cnt       <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= BUSY;
                        owner_q  <= owner_sel;
                        last_gnt <= owner_sel;
                        cnt      <= CW'(MEM_LAT);
                        if (MEM_LAT == 1) begin
                            if_rvalid <= (owner_sel == REQ_IF);
                            dm_rvalid <= (owner_sel == REQ_DM);
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt_w == 32'd1) begin
                        state <= IDLE;
                    end else if (cnt_w == 32'd2) begin
                        if_rvalid <= (owner_q == REQ_IF);
                        dm_rvalid <= (owner_q == REQ_DM);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with MEM_LAT = 1 (a) and one with MEM_LAT = 3 (b), shared requesters.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    logic        if_gnt_a, if_rvalid_a, dm_gnt_a, dm_rvalid_a, mem_en_a, mem_we_a;
    logic [31:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        if_gnt_b, if_rvalid_b, dm_gnt_b, dm_rvalid_b, mem_en_b, mem_we_b;
    logic [31:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_a), .dm_rvalid(dm_rvalid_a), .rdata(rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_b), .dm_rvalid(dm_rvalid_b), .rdata(rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: unwritten words read as {16'hC0DE, addr[15:0]}.
    logic [31:0]  mem_a [0:255];
    logic [255:0] vld_a;
    logic [31:0]  pipe_a;
    logic [7:0]   idx_a;
    logic [31:0]  mem_b [0:255];
    logic [255:0] vld_b;
    logic [31:0]  pipe_b [0:2];
    logic [7:0]   idx_b;

    assign idx_a       = mem_addr_a[9:2];
    assign idx_b       = mem_addr_b[9:2];
    assign mem_rdata_a = pipe_a;
    assign mem_rdata_b = pipe_b[2];

    always @(posedge clk) begin
        if (reset) begin
            vld_a <= '0;
        end else if (mem_en_a && mem_we_a) begin
            mem_a[idx_a] <= mem_wdata_a;
            vld_a[idx_a] <= 1'b1;
        end
        pipe_a <= vld_a[idx_a] ? mem_a[idx_a] : {16'hC0DE, mem_addr_a[15:0]};
    end

    always @(posedge clk) begin
        if (reset) begin
            vld_b <= '0;
        end else if (mem_en_b && mem_we_b) begin
            mem_b[idx_b] <= mem_wdata_b;
            vld_b[idx_b] <= 1'b1;
        end
        pipe_b[0] <= vld_b[idx_b] ? mem_b[idx_b] : {16'hC0DE, mem_addr_b[15:0]};
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;

        // Reset defaults
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt",    {31'd0, if_gnt_b},    32'd0);
        chk("rst_dm_gnt",    {31'd0, dm_gnt_b},    32'd0);
        chk("rst_if_rvalid", {31'd0, if_rvalid_b}, 32'd0);
        chk("rst_dm_rvalid", {31'd0, dm_rvalid_b}, 32'd0);
        chk("rst_mem_en",    {31'd0, mem_en_b},    32'd0);
        chk("rst_mem_we",    {31'd0, mem_we_b},    32'd0);
        chk("rst_a_rvalid",  {30'd0, if_rvalid_a, dm_rvalid_a}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) reset = 1'b0;
            @(negedge clk);
            chk("idle_mem_en", {30'd0, mem_en_a, mem_en_b}, 32'd0);
        end

        // Single fetch on MEM_LAT = 1, back-to-back request
        tick(); if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("f_if_gnt",   {31'd0, if_gnt_a}, 32'd1);
        chk("f_mem_en",   {31'd0, mem_en_a}, 32'd1);
        chk("f_mem_addr", mem_addr_a,        32'h100);
        chk("f_mem_we",   {31'd0, mem_we_a}, 32'd0);
        chk("f_dm_gnt",   {31'd0, dm_gnt_a}, 32'd0);
        tick(); if_addr = 32'h104;
        @(negedge clk);
        chk("f_no_gnt_t1", {31'd0, if_gnt_a},    32'd0);
        chk("f_rvalid_t1", {31'd0, if_rvalid_a}, 32'd1);
        chk("f_rdata_t1",  rdata_a,              32'hC0DE0100);
        tick();
        @(negedge clk);
        chk("f_gnt_t2",  {31'd0, if_gnt_a}, 32'd1);
        chk("f_addr_t2", mem_addr_a,        32'h104);
        tick(); if_req = 1'b0;
        @(negedge clk);
        chk("f_rvalid_t3",  {31'd0, if_rvalid_a}, 32'd1);
        chk("f_rdata_t3",   rdata_a,              32'hC0DE0104);
        chk("f_b_rvalid",   {31'd0, if_rvalid_b}, 32'd1);
        chk("f_b_rdata",    rdata_b,              32'hC0DE0100);

        // Store then load on MEM_LAT = 3
        tick(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("st_gnt",   {31'd0, dm_gnt_b}, 32'd1);
        chk("st_en",    {31'd0, mem_en_b}, 32'd1);
        chk("st_we",    {31'd0, mem_we_b}, 32'd1);
        chk("st_addr",  mem_addr_b,        32'h2000);
        chk("st_wdata", mem_wdata_b,       32'hDEADBEEF);
        tick(); dm_req = 1'b0;
        @(negedge clk);
        chk("st_rv_t1", {31'd0, dm_rvalid_b}, 32'd0);
        tick();
        @(negedge clk);
        chk("st_rv_t2", {31'd0, dm_rvalid_b}, 32'd0);
        chk("st_en_t2", {31'd0, mem_en_b},    32'd0);
        tick();
        @(negedge clk);
        chk("st_rv_t3", {31'd0, dm_rvalid_b}, 32'd1);
        tick(); dm_req = 1'b1; dm_we = 1'b0;
        @(negedge clk);
        chk("ld_gnt", {31'd0, dm_gnt_b}, 32'd1);
        chk("ld_we",  {31'd0, mem_we_b}, 32'd0);
        tick(); dm_req = 1'b0;
        @(negedge clk);
        chk("ld_rv_t5", {31'd0, dm_rvalid_b}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk("ld_rv_t7",    {31'd0, dm_rvalid_b}, 32'd1);
        chk("ld_rdata_t7", rdata_b,              32'hDEADBEEF);

        // Reset in the middle of a MEM_LAT = 3 load
        tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        @(negedge clk);
        chk("rm_gnt", {31'd0, dm_gnt_b}, 32'd1);
        tick(); dm_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rm_b_rv", {31'd0, dm_rvalid_b}, 32'd0);
        chk("rm_a_rv", {31'd0, dm_rvalid_a}, 32'd0);
        tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rm_no_rv", {31'd0, dm_rvalid_b}, 32'd0);
            chk("rm_no_en", {31'd0, mem_en_b},    32'd0);
            tick();
        end

        // Continuous contention on MEM_LAT = 3: DM first, then alternating
        if_req = 1'b1; if_addr = 32'h300; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2004;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    chk("cn_dm_gnt", {31'd0, dm_gnt_b}, (k % 2 == 0) ? 32'd1 : 32'd0);
                    chk("cn_if_gnt", {31'd0, if_gnt_b}, (k % 2 == 1) ? 32'd1 : 32'd0);
                    chk("cn_addr",   mem_addr_b,        (k % 2 == 0) ? 32'h2004 : 32'h300);
                end else begin
                    chk("cn_busy_gnt", {30'd0, if_gnt_b, dm_gnt_b}, 32'd0);
                    chk("cn_busy_en",  {31'd0, mem_en_b},           32'd0);
                end
                if (c == 3) begin
                    chk("cn_rv", {30'd0, if_rvalid_b, dm_rvalid_b},
                        (k % 2 == 0) ? 32'd1 : 32'd2);
                end
                tick();
            end
        end

        // Fetch request raised and withdrawn while a store is outstanding
        if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2008; dm_wdata = 32'h12345678;
        @(negedge clk);
        chk("wd_dm_gnt", {31'd0, dm_gnt_b}, 32'd1);
        chk("wd_we",     {31'd0, mem_we_b}, 32'd1);
        chk("wd_wdata",  mem_wdata_b,       32'h12345678);
        tick(); dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h400;
        @(negedge clk);
        chk("wd_if_gnt1", {31'd0, if_gnt_b}, 32'd0);
        chk("wd_en1",     {31'd0, mem_en_b}, 32'd0);
        tick(); if_req = 1'b0;
        @(negedge clk);
        chk("wd_if_gnt2", {31'd0, if_gnt_b}, 32'd0);
        chk("wd_en2",     {31'd0, mem_en_b}, 32'd0);
        tick();
        @(negedge clk);
        chk("wd_dm_rv", {31'd0, dm_rvalid_b}, 32'd1);
        chk("wd_if_rv", {31'd0, if_rvalid_b}, 32'd0);
        tick();
        @(negedge clk);
        chk("wd_en4",     {31'd0, mem_en_b}, 32'd0);
        chk("wd_if_gnt4", {31'd0, if_gnt_b}, 32'd0);
        tick();
        @(negedge clk);
        chk("wd_if_rv5", {31'd0, if_rvalid_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch port (requester 0) and the load/store port (requester 1) of the RISC V core. It issues one memory access at a time and selects address and write data by requester. It waits a fixed memory latency, then returns the read data or write acknowledge to the owning requester. Arbitration is round-robin, so neither port starves. The block sits between the core's fetch/LSU logic and the memory macro.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from issue to mem_rdata valid; legal range 1..15
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse; rdata holds fetch data
- dm_req  in  1  data request; held with dm_addr/dm_we/dm_wdata stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  one-cycle pulse; load data valid, or store acknowledge
- rdata  out  DW  mem_rdata passed through, shared by both ports
- mem_en  out  1  access strobe, one cycle per transaction
- mem_we  out  1  write enable; qualified by mem_en
- mem_addr  out  AW  selected address
- mem_wdata  out  DW  dm_wdata; driven only when the data port owns the access
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding.
- Owner selection in IDLE:
  - Only one requester active: that requester is the owner.
  - Both active: the owner is the requester not granted last (last_gnt).
- Issue in IDLE when any request is active:
  - Combinationally assert the owner's gnt, plus mem_en.
  - Drive mem_addr from the owner's address.
  - mem_we = dm_we if the owner is the data port, else 0.
  - On the clock edge: latch owner, update last_gnt = owner, load cnt = MEM_LAT, go to BUSY.
- BUSY:
  - cnt decrements each cycle.
  - Leaving IDLE is the first decrement, so the cycle where cnt == 1 is exactly MEM_LAT cycles after the issue cycle.
  - In the cnt == 1 cycle, assert the owner's rvalid, then go to IDLE.
  - No gnt and no mem_en while BUSY; requests are ignored and held.
- Stores: rvalid is a completion acknowledge and rdata content is don't-care.
- Outside issue cycles, mem_addr and mem_we are don't-care.
- When mem_en is 0, mem_we must be 0.
- Request dropped before gnt: legal, and no side effect.
- Reset values:
  - state IDLE, last_gnt = 0 (fetch), so the first contention goes to the data port.
  - cnt 0; if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we all 0.
- Reset asserted mid-BUSY: the transaction is abandoned, no rvalid is produced, and the late mem_rdata is ignored.

## Timing
- gnt and mem_en are combinational from req in IDLE, with zero-cycle acceptance.
- rvalid is registered in the state machine, MEM_LAT cycles after the gnt cycle.
- The earliest next grant is the cycle after rvalid.
- Throughput is 1 transaction per MEM_LAT+1 cycles.
- rdata = mem_rdata combinationally. It is sampled by the requester only on its rvalid.
- cnt width = $clog2(MEM_LAT+1).

## Structure
- Shared package holds:
  - the state enum (IDLE, BUSY)
  - requester ids REQ_IF = 1'b0, REQ_DM = 1'b1
  - MEM_LAT upper bound constant
- Address selection uses one instance of the existing datapath mux2 (WIDTH = AW, sel = owner, D0 = if_addr, D1 = dm_addr).
- Remaining logic (FSM, counter, round-robin bit) is inline.

## Test plan
- **Reset defaults:** reset high for 3 cycles, then low, with no requests -> all outputs 0, and mem_en stays 0 for 10 cycles.
- **Single fetch, MEM_LAT = 1:**
  - if_req with if_addr = 0x100 at cycle T -> if_gnt = 1 and mem_en = 1 with mem_addr = 0x100 at T.
  - if_rvalid = 1 at T+1 with rdata = mem_rdata; next grant no earlier than T+2.
- **Store then load, MEM_LAT = 3:**
  - Store dm_addr = 0x2000, dm_wdata = 0xDEADBEEF -> mem_we = 1 at issue, dm_rvalid at T+3.
  - Load of 0x2000 issued at T+4 -> rdata = 0xDEADBEEF on dm_rvalid at T+7.
- **Continuous contention:** if_req and dm_req both held for 8 transactions -> grant order DM, IF, DM, IF…, and neither port waits more than one other transaction.
- **Reset mid-transaction:** reset pulsed at T+1 of a MEM_LAT = 3 load -> no dm_rvalid ever, state IDLE, and the next contention is granted to DM.
- **Request withdrawn while BUSY:** if_req raised then dropped during BUSY -> no if_gnt and no mem_en for it, and the pending data request completes normally.
